// File: rtl/main.sv
// -----------------------------------------------------------------------------
// main -- game logic for the VGA falling-block game.
//
// A player square sits on a fixed row near the bottom of the screen and is
// steered left/right by held PS/2 keys ('A' / 'D').  One obstacle square falls
// from the top.  Each time it leaves the bottom of the screen the score goes
// up, the fall gets faster, and a new column is picked from a 10-bit LFSR.
// All game state advances exactly once per video frame, on a tick derived
// from the rising edge of VGA vsync.  A collision between the two squares
// ends the game and freezes everything until reset.
//
// Ports
//   clk       in   1   system clock, all state on the rising edge
//   reset     in   1   asynchronous, active-high
//   vs        in   1   VGA vertical sync (asynchronous); rising edge = frame tick
//   keyboard  in  10   held key: [7:0] scan code, [8] extended, [9] break
//   x         in  10   pixel column being scanned (0..639 visible)
//   y         in   9   pixel row being scanned (0..479 visible)
//   RGB       out 12   {R,G,B} 4 bits each, colour for pixel (x,y)
//   stop      out  1   game over, held until reset
// -----------------------------------------------------------------------------
module main (
    input  logic        clk,
    input  logic        reset,
    input  logic        vs,
    input  logic [9:0]  keyboard,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    output logic [11:0] RGB,
    output logic        stop
);

    // Screen and object geometry
    localparam logic [10:0] SCREEN_W     = 11'd640;
    localparam logic [10:0] SCREEN_H     = 11'd480;
    localparam logic [10:0] BLOCK        = 11'd32;
    localparam logic [10:0] PLAYER_TOP   = 11'd416;
    localparam logic [10:0] PLAYER_BOT   = 11'd448;  // exclusive
    localparam logic [10:0] GROUND_TOP   = 11'd448;
    localparam logic [10:0] GROUND_BOT   = 11'd452;  // exclusive
    localparam logic [9:0]  PX_MAX       = 10'd608;
    localparam logic [9:0]  PX_STEP      = 10'd4;
    localparam logic [9:0]  OY_LIMIT     = 10'd480;

    // Reset state
    localparam logic [9:0]  PX_RESET     = 10'd304;
    localparam logic [9:0]  OX_RESET     = 10'd64;
    localparam logic [9:0]  LFSR_RESET   = 10'h2A5;

    // Key codes
    localparam logic [7:0]  KEY_A        = 8'h1C;
    localparam logic [7:0]  KEY_D        = 8'h23;

    // Colours
    localparam logic [11:0] COL_BLACK    = 12'h000;
    localparam logic [11:0] COL_PLAYER   = 12'h0F0;
    localparam logic [11:0] COL_DEAD     = 12'hF00;
    localparam logic [11:0] COL_OBST     = 12'h00F;
    localparam logic [11:0] COL_GROUND   = 12'hFFF;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic        r_vs_s1;
    logic        r_vs_s2;
    logic        r_vs_s3;
    logic [9:0]  r_px;
    logic [9:0]  r_ox;
    logic [9:0]  r_oy;
    logic [7:0]  r_score;
    logic [9:0]  r_lfsr;
    logic        r_stop;

    // -------------------------------------------------------------------------
    // Combinational next-state and decode
    // -------------------------------------------------------------------------
    logic        w_tick;
    logic        w_left;
    logic        w_right;
    logic [9:0]  w_px_next;
    logic [4:0]  w_score_div8;
    logic [3:0]  w_speed_bonus;
    logic [9:0]  w_speed;
    logic [9:0]  w_oy_sum;
    logic        w_wrap;
    logic [9:0]  w_ox_spawn;
    logic [9:0]  w_lfsr_next;
    logic [7:0]  w_score_next;
    logic        w_hit;

    // A single-cycle pulse on the first clock where the synchronised vsync
    // is seen high; a long vsync high level still gives only one tick.
    assign w_tick = r_vs_s2 & ~r_vs_s3;

    // Only plain make codes steer; break or extended codes are ignored.
    assign w_left  = (keyboard[9:8] == 2'b00) && (keyboard[7:0] == KEY_A);
    assign w_right = (keyboard[9:8] == 2'b00) && (keyboard[7:0] == KEY_D);

    always_comb begin
        w_px_next = r_px;
        if (w_left) begin
            w_px_next = (r_px < PX_STEP) ? 10'd0 : (r_px - PX_STEP);
        end else if (w_right) begin
            w_px_next = (r_px > (PX_MAX - PX_STEP)) ? PX_MAX : (r_px + PX_STEP);
        end
    end

    // Fall speed grows by one pixel per frame for every 8 points, capped at +8.
    assign w_score_div8  = r_score[7:3];
    assign w_speed_bonus = (w_score_div8 > 5'd8) ? 4'd8 : w_score_div8[3:0];
    assign w_speed       = 10'd4 + {6'd0, w_speed_bonus};

    // r_oy never exceeds 479 and speed never exceeds 12, so 10 bits suffice.
    assign w_oy_sum = r_oy + w_speed;
    assign w_wrap   = (w_oy_sum >= OY_LIMIT);

    // LFSR values above the last legal column are folded back by 512 so the
    // obstacle always spawns fully on screen.
    assign w_ox_spawn   = (r_lfsr <= PX_MAX) ? r_lfsr : (r_lfsr - 10'd512);
    assign w_lfsr_next  = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    assign w_score_next = (r_score == 8'hFF) ? r_score : (r_score + 8'd1);

    // Axis-aligned overlap of the two 32x32 squares, evaluated on the
    // current registers; widened so the +32 sums cannot wrap.
    assign w_hit = ({1'b0, r_px} < ({1'b0, r_ox} + BLOCK)) &&
                   ({1'b0, r_ox} < ({1'b0, r_px} + BLOCK)) &&
                   (({1'b0, r_oy} + BLOCK) > PLAYER_TOP) &&
                   ({1'b0, r_oy} < PLAYER_BOT);

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_vs_s3 <= 1'b0;
            r_px    <= PX_RESET;
            r_ox    <= OX_RESET;
            r_oy    <= 10'd0;
            r_score <= 8'd0;
            r_lfsr  <= LFSR_RESET;
            r_stop  <= 1'b0;
        end else begin
            r_vs_s1 <= vs;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;

            if (w_tick && !r_stop) begin
                if (w_hit) begin
                    // The collision frame itself moves nothing, so the final
                    // picture shows the squares exactly where they met.
                    r_stop <= 1'b1;
                end else begin
                    r_px <= w_px_next;
                    if (w_wrap) begin
                        r_oy    <= 10'd0;
                        r_ox    <= w_ox_spawn;
                        r_score <= w_score_next;
                        r_lfsr  <= w_lfsr_next;
                    end else begin
                        r_oy    <= w_oy_sum;
                    end
                end
            end
        end
    end

    assign stop = r_stop;

    // -------------------------------------------------------------------------
    // Pixel colour
    // -------------------------------------------------------------------------
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_visible;
    logic        w_in_player;
    logic        w_in_obst;
    logic        w_in_ground;

    assign w_x = {1'b0, x};
    assign w_y = {2'b00, y};

    assign w_visible   = (w_x < SCREEN_W) && (w_y < SCREEN_H);

    assign w_in_player = (w_x >= {1'b0, r_px}) && (w_x < ({1'b0, r_px} + BLOCK)) &&
                         (w_y >= PLAYER_TOP)   && (w_y < PLAYER_BOT);

    assign w_in_obst   = (w_x >= {1'b0, r_ox}) && (w_x < ({1'b0, r_ox} + BLOCK)) &&
                         (w_y >= {1'b0, r_oy}) && (w_y < ({1'b0, r_oy} + BLOCK));

    assign w_in_ground = (w_y >= GROUND_TOP) && (w_y < GROUND_BOT);

    always_comb begin
        RGB = COL_BLACK;
        if (!w_visible) begin
            RGB = COL_BLACK;
        end else if (w_in_player) begin
            RGB = r_stop ? COL_DEAD : COL_PLAYER;
        end else if (w_in_obst) begin
            RGB = COL_OBST;
        end else if (w_in_ground) begin
            RGB = COL_GROUND;
        end
    end

endmodule

// File: tb/tb_main.sv
// -----------------------------------------------------------------------------
// tb_main -- directed bench for the falling-block game logic.
// Expected colours and positions are worked out by hand from the game rules
// and checked through pixel probes of RGB and the stop flag.
// -----------------------------------------------------------------------------
module tb_main;

    logic        clk;
    logic        reset;
    logic        vs;
    logic [9:0]  keyboard;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] RGB;
    logic        stop;

    int n_vec;
    int n_err;

    main dut (
        .clk      (clk),
        .reset    (reset),
        .vs       (vs),
        .keyboard (keyboard),
        .x        (x),
        .y        (y),
        .RGB      (RGB),
        .stop     (stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic pix(input string tag, input int px, input int py, input logic [11:0] exp_v);
        x = px[9:0];
        y = py[8:0];
        #1;
        check(tag, RGB, exp_v);
    endtask

    task automatic chk_stop(input string tag, input logic exp_v);
        check(tag, {11'd0, stop}, {11'd0, exp_v});
    endtask

    // One vsync pulse: several clocks high then several low, so the frame
    // update has landed before the caller looks at anything.
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vs = 1'b1;
            repeat (4) @(negedge clk);
            vs = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        vs       = 1'b0;
        keyboard = 10'd0;
        x        = 10'd0;
        y        = 9'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset picture: player 304..335 x 416..447, obstacle 64..95 x 0..31
        pix("rst_player",     320, 430, 12'h0F0);
        pix("rst_bg",          20, 280, 12'h000);
        pix("rst_ground",      20, 450, 12'hFFF);
        pix("rst_ground_top",  20, 448, 12'hFFF);
        pix("rst_below_gnd",   20, 452, 12'h000);
        pix("rst_obst",        70,  10, 12'h00F);
        pix("rst_off_x",      640, 450, 12'h000);
        pix("rst_off_y",       20, 480, 12'h000);
        chk_stop("rst_stop", 1'b0);

        // Five left steps: px 304 -> 284, obstacle oy 0 -> 20
        keyboard = 10'h01C;
        pulses(5);
        pix("left5_edge",     284, 420, 12'h0F0);
        pix("left5_before",   283, 420, 12'h000);
        pix("left5_right",    315, 420, 12'h0F0);
        pix("left5_after",    316, 420, 12'h000);
        pix("fall5_top",       70,  20, 12'h00F);
        pix("fall5_above",     70,  19, 12'h000);

        // Left held for 100 frames: clamps at 0 (obstacle oy=400, no contact)
        do_reset();
        keyboard = 10'h01C;
        pulses(100);
        pix("clamp0_left",      0, 420, 12'h0F0);
        pix("clamp0_right",    31, 420, 12'h0F0);
        pix("clamp0_past",     32, 420, 12'h000);
        chk_stop("clamp0_stop", 1'b0);

        // Right held for 200 frames from 304: clamps at 608; obstacle wrapped
        // at frame 120 to ox=165 and has since fallen 80*4=320
        do_reset();
        keyboard = 10'h023;
        pulses(200);
        pix("clamp608_left",  608, 420, 12'h0F0);
        pix("clamp608_right", 639, 420, 12'h0F0);
        pix("clamp608_before",607, 420, 12'h000);
        pix("wrap_ox_in",     165, 330, 12'h00F);
        pix("wrap_ox_before", 164, 330, 12'h000);
        chk_stop("clamp608_stop", 1'b0);

        // Break and extended codes do not steer
        keyboard = 10'h21C;
        pulses(10);
        pix("break_hold",     608, 420, 12'h0F0);
        pix("break_before",   607, 420, 12'h000);
        keyboard = 10'h11C;
        pulses(5);
        pix("ext_hold",       608, 420, 12'h0F0);
        pix("ext_before",     607, 420, 12'h000);

        // Free fall at 4 px/frame from ox=64
        do_reset();
        keyboard = 10'h000;
        pulses(30);
        pix("fall30_in",       70, 125, 12'h00F);
        pix("fall30_above",    70, 119, 12'h000);
        pix("fall30_bottom",   70, 151, 12'h00F);
        pix("fall30_below",    70, 152, 12'h000);
        pulses(89);
        pix("fall119_in",      70, 476, 12'h00F);
        pulses(1);
        pix("wrap_left",      165,   5, 12'h00F);
        pix("wrap_before",    164,   5, 12'h000);
        pix("wrap_right",     196,   5, 12'h00F);
        pix("wrap_after",     197,   5, 12'h000);
        pix("wrap_old_gone",   70, 476, 12'h000);
        pix("wrap_old_top",    70,   5, 12'h000);
        chk_stop("wrap_stop", 1'b0);

        // Collision: 60 left steps put px at 64 under ox=64 (oy=240 then).
        // oy reaches 388 after 97 frames; frame 98 sees the overlap.
        do_reset();
        keyboard = 10'h01C;
        pulses(60);
        keyboard = 10'h000;
        pix("under_edge",      64, 420, 12'h0F0);
        pix("under_before",    63, 420, 12'h000);
        pulses(37);
        chk_stop("pre_hit_stop", 1'b0);
        pix("pre_hit_player",  64, 420, 12'h0F0);
        pulses(1);
        chk_stop("hit_stop", 1'b1);
        pix("hit_player",      64, 420, 12'hF00);
        pix("hit_player_r",    95, 420, 12'hF00);
        pix("hit_obst_top",    64, 388, 12'h00F);
        pix("hit_obst_above",  64, 387, 12'h000);

        // Frozen after game over
        keyboard = 10'h01C;
        pulses(5);
        chk_stop("frozen_stop", 1'b1);
        pix("frozen_player",   64, 420, 12'hF00);
        pix("frozen_before",   63, 420, 12'h000);
        pix("frozen_obst",     64, 388, 12'h00F);
        pix("frozen_above",    64, 387, 12'h000);

        // Asynchronous reset takes effect before any clock edge
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_stop("async_rst_stop", 1'b0);
        pix("async_rst_player", 320, 430, 12'h0F0);
        pix("async_rst_old",     64, 420, 12'h000);

        // A vsync pulse while reset is held must not move the player
        keyboard = 10'h01C;
        @(negedge clk);
        vs = 1'b1;
        repeat (4) @(negedge clk);
        vs = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        pix("rst_vs_edge",    304, 420, 12'h0F0);
        pix("rst_vs_before",  303, 420, 12'h000);
        chk_stop("rst_vs_stop", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
